// File: rtl/store_align_queue.sv
// -----------------------------------------------------------------------------
// store_align_queue
//   Store path between execute and the data-memory port. Each request is
//   rotated onto the byte lanes of a little-endian DATA_W-wide memory and gets
//   byte strobes. Misaligned or reserved requests are consumed and reported
//   with a one-cycle address-error pulse. Aligned stores wait in a DEPTH-entry
//   FIFO and drain through a valid/ready handshake. A store to the same word as
//   the tail entry can be write-combined into it (never into the head), and a
//   load-hazard query reports whether any pending entry covers a load's word.
//
// Ports
//   clk, resetn          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready    request handshake; in_ready = not full
//   in_op                0=SB 1=SH 2=SW 3=SWL 4=SWR, 5..7 reserved (error)
//   in_addr, in_data     byte address and register source value
//   out_valid/out_ready  head-entry handshake toward memory
//   out_addr/data/strb   word address, aligned write data, byte enables
//   ade, ade_addr        misaligned-store pulse and held faulting address
//   ld_addr, ld_hit      load-hazard query (combinational)
//   empty                no pending entries
// -----------------------------------------------------------------------------
module store_align_queue #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int DEPTH    = 4,
  parameter int MERGE_EN = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_op,
  input  logic [ADDR_W-1:0]     in_addr,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_W-1:0]     out_addr,
  output logic [DATA_W-1:0]     out_data,
  output logic [DATA_W/8-1:0]   out_strb,
  output logic                  ade,
  output logic [ADDR_W-1:0]     ade_addr,
  input  logic [ADDR_W-1:0]     ld_addr,
  output logic                  ld_hit,
  output logic                  empty
);

  localparam int NB = DATA_W / 8;
  localparam int OW = $clog2(NB);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [2:0] OP_SB  = 3'd0;
  localparam logic [2:0] OP_SH  = 3'd1;
  localparam logic [2:0] OP_SW  = 3'd2;
  localparam logic [2:0] OP_SWL = 3'd3;
  localparam logic [2:0] OP_SWR = 3'd4;

  // Alignment datapath
  logic [OW-1:0]     off_s;
  logic [ADDR_W-1:0] wa_s;
  logic [DATA_W-1:0] b_rep_s;
  logic [DATA_W-1:0] hw_rep_s;
  logic [DATA_W-1:0] al_data_s;
  logic [NB-1:0]     al_strb_s;
  logic              mis_s;

  // FIFO state
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [NB-1:0]     strb_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              ade_q, ade_d;
  logic [ADDR_W-1:0] ade_addr_q, ade_addr_d;

  // FIFO control / write port
  logic              accept_s, pop_s, can_merge_s, merge_s, push_s;
  logic [PW-1:0]     tail_s;
  logic              wr_en_s;
  logic [PW-1:0]     wr_idx_s;
  logic [DATA_W-1:0] ent_data_s;
  logic [NB-1:0]     ent_strb_s;
  logic [ADDR_W-1:0] ld_word_s;
  logic              ld_hit_s;
  logic              unused_ok_s;

  assign off_s     = in_addr[OW-1:0];
  assign wa_s      = {in_addr[ADDR_W-1:OW], {OW{1'b0}}};
  assign ld_word_s = {ld_addr[ADDR_W-1:OW], {OW{1'b0}}};
  // Low bits of the query address do not affect the word match.
  assign unused_ok_s = ^ld_addr[OW-1:0];

  // Lane rotation, strobe generation and misalignment detection per opcode.
  always_comb begin
    for (int i = 0; i < NB; i++) begin
      b_rep_s[8*i +: 8]  = in_data[7:0];
      hw_rep_s[8*i +: 8] = in_data[8*(i%2) +: 8];
    end
    al_data_s = in_data;
    al_strb_s = {NB{1'b0}};
    mis_s     = 1'b1;
    case (in_op)
      OP_SB: begin
        al_data_s = b_rep_s;
        al_strb_s = NB'(1'b1) << off_s;
        mis_s     = 1'b0;
      end
      OP_SH: begin
        al_data_s = hw_rep_s;
        al_strb_s = NB'(2'b11) << off_s;
        mis_s     = off_s[0];
      end
      OP_SW: begin
        al_data_s = in_data;
        al_strb_s = {NB{1'b1}};
        mis_s     = (off_s != {OW{1'b0}});
      end
      OP_SWL: begin
        // NB-1-o equals ~o because NB is a power of two.
        al_data_s = in_data >> {~off_s, 3'b000};
        al_strb_s = {NB{1'b1}} >> (~off_s);
        mis_s     = 1'b0;
      end
      OP_SWR: begin
        al_data_s = in_data << {off_s, 3'b000};
        al_strb_s = {NB{1'b1}} << off_s;
        mis_s     = 1'b0;
      end
      default: begin
        al_data_s = in_data;
        al_strb_s = {NB{1'b0}};
        mis_s     = 1'b1;
      end
    endcase
  end

  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != {CW{1'b0}});
  assign empty     = (count_q == {CW{1'b0}});
  assign accept_s  = in_valid && in_ready;
  assign pop_s     = out_valid && out_ready;
  assign tail_s    = wr_ptr_q - PW'(1'b1);

  // count >= 2 keeps the tail distinct from the head, so a merge can never
  // modify an entry that memory may be consuming this cycle.
  assign can_merge_s = (MERGE_EN != 0) && (count_q >= CW'(2'd2)) &&
                       (addr_q[tail_s] == wa_s);
  assign merge_s = accept_s && !mis_s && can_merge_s;
  assign push_s  = accept_s && !mis_s && !can_merge_s;

  // Write-port selection: new tail entry, or byte-merge into the current tail.
  always_comb begin
    wr_en_s    = 1'b0;
    wr_idx_s   = wr_ptr_q;
    ent_data_s = al_data_s;
    ent_strb_s = al_strb_s;
    if (merge_s) begin
      wr_en_s  = 1'b1;
      wr_idx_s = tail_s;
      for (int j = 0; j < NB; j++) begin
        ent_data_s[8*j +: 8] = al_strb_s[j] ? al_data_s[8*j +: 8]
                                            : data_q[tail_s][8*j +: 8];
      end
      ent_strb_s = strb_q[tail_s] | al_strb_s;
    end else if (push_s) begin
      wr_en_s = 1'b1;
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Pointer, occupancy and address-error next state.
  always_comb begin
    wr_ptr_d   = wr_ptr_q + PW'(push_s);
    rd_ptr_d   = rd_ptr_q + PW'(pop_s);
    count_d    = count_q + CW'(push_s) - CW'(pop_s);
    ade_d      = accept_s && mis_s;
    ade_addr_d = ade_d ? in_addr : ade_addr_q;
  end

  // Control registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q   <= {PW{1'b0}};
      rd_ptr_q   <= {PW{1'b0}};
      count_q    <= {CW{1'b0}};
      ade_q      <= 1'b0;
      ade_addr_q <= {ADDR_W{1'b0}};
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ade_q      <= ade_d;
      ade_addr_q <= ade_addr_d;
    end
  end

  // Entry storage.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < DEPTH; k++) begin
        addr_q[k] <= {ADDR_W{1'b0}};
        data_q[k] <= {DATA_W{1'b0}};
        strb_q[k] <= {NB{1'b0}};
      end
    end else if (wr_en_s) begin
      addr_q[wr_idx_s] <= wa_s;
      data_q[wr_idx_s] <= ent_data_s;
      strb_q[wr_idx_s] <= ent_strb_s;
    end
  end

  // Load-hazard query: an entry is live when its distance from the head is
  // below the occupancy.
  always_comb begin
    ld_hit_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      ld_hit_s = ld_hit_s |
                 (({1'b0, PW'(i) - rd_ptr_q} < count_q) && (addr_q[i] == ld_word_s));
    end
  end

  assign out_addr = addr_q[rd_ptr_q];
  assign out_data = data_q[rd_ptr_q];
  assign out_strb = strb_q[rd_ptr_q];
  assign ade      = ade_q;
  assign ade_addr = ade_addr_q;
  assign ld_hit   = ld_hit_s;

endmodule

// File: tb/tb_store_align_queue.sv
// -----------------------------------------------------------------------------
// tb_store_align_queue
//   Directed and randomized stimulus for store_align_queue, checked every cycle
//   against a queue-based reference model of the store FIFO.
// -----------------------------------------------------------------------------
module tb_store_align_queue;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } ent_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_addr;
  logic [31:0] out_data;
  logic [3:0]  out_strb;
  logic        ade;
  logic [31:0] ade_addr;
  logic [31:0] ld_addr;
  logic        ld_hit;
  logic        empty;

  int n_checks = 0;
  int n_errors = 0;

  ent_t        q[$];
  logic        m_ade = 1'b0;
  logic [31:0] m_ade_addr = 32'h0;

  store_align_queue #(
    .DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .MERGE_EN(1)
  ) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_addr(in_addr), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data), .out_strb(out_strb),
    .ade(ade), .ade_addr(ade_addr),
    .ld_addr(ld_addr), .ld_hit(ld_hit), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: lane strobes and data straight from the store rules.
  task automatic model_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d,
                           output logic mis, output logic [31:0] wa,
                           output logic [31:0] dat, output logic [3:0] st);
    int o;
    o   = int'(a % 4);
    wa  = a - 32'(o);
    mis = 1'b0;
    dat = d;
    st  = 4'b0000;
    case (op)
      3'd0: begin
        dat = {4{d[7:0]}};
        for (int l = 0; l < 4; l++) st[l] = (l == o);
      end
      3'd1: begin
        dat = {2{d[15:0]}};
        mis = (o % 2) != 0;
        for (int l = 0; l < 4; l++) st[l] = (l == o) || (l == o + 1);
      end
      3'd2: begin
        mis = (o != 0);
        st  = 4'b1111;
      end
      3'd3: begin
        dat = d >> (8 * (3 - o));
        for (int l = 0; l < 4; l++) st[l] = (l <= o);
      end
      3'd4: begin
        dat = d << (8 * o);
        for (int l = 0; l < 4; l++) st[l] = (l >= o);
      end
      default: mis = 1'b1;
    endcase
  endtask

  task automatic check_all();
    logic [31:0] law;
    logic        hit;
    law = ld_addr & ~32'h3;
    hit = 1'b0;
    foreach (q[i]) if (q[i].a == law) hit = 1'b1;
    chk("in_ready", in_ready, q.size() != DEPTH);
    chk("out_valid", out_valid, q.size() != 0);
    chk("empty", empty, q.size() == 0);
    chk("ade", ade, m_ade);
    chk("ade_addr", ade_addr, m_ade_addr);
    chk("ld_hit", ld_hit, hit);
    if (q.size() != 0) begin
      chk("out_addr", out_addr, q[0].a);
      chk("out_data", out_data, q[0].d);
      chk("out_strb", out_strb, q[0].s);
    end
  endtask

  // One clock of stimulus: drive, predict, clock, update model, compare.
  task automatic step(input logic v, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] d, input logic ordy, input logic [31:0] la);
    logic        mis;
    logic [31:0] wa, dat;
    logic [3:0]  st;
    logic        acc, pop, mrg;
    ent_t        e;
    in_valid = v; in_op = op; in_addr = a; in_data = d; out_ready = ordy; ld_addr = la;
    model_req(op, a, d, mis, wa, dat, st);
    acc = v && (q.size() != DEPTH);
    pop = (q.size() != 0) && ordy;
    mrg = acc && !mis && (q.size() >= 2) && (q[q.size()-1].a == wa);
    @(posedge clk);
    #1;
    if (mrg) begin
      e = q[q.size()-1];
      for (int l = 0; l < 4; l++) if (st[l]) e.d[8*l +: 8] = dat[8*l +: 8];
      e.s = e.s | st;
      q[q.size()-1] = e;
    end
    if (pop) e = q.pop_front();
    if (acc && !mis && !mrg) begin
      e.a = wa; e.d = dat; e.s = st;
      q.push_back(e);
    end
    m_ade = acc && mis;
    if (m_ade) m_ade_addr = a;
    check_all();
  endtask

  initial begin
    resetn = 1'b0; in_valid = 1'b0; in_op = 3'd0; in_addr = 32'h0;
    in_data = 32'h0; out_ready = 1'b0; ld_addr = 32'h0;
    #1;
    check_all();
    chk("rst_out_addr", out_addr, 32'h0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_strb", out_strb, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    resetn = 1'b1;

    // SWL into lanes 1..0
    step(1'b1, 3'd3, 32'h1000_0001, 32'hAABBCCDD, 1'b0, 32'h0);
    chk("swl_addr", out_addr, 32'h1000_0000);
    chk("swl_strb", out_strb, 32'h3);
    chk("swl_lo", out_data[15:0], 32'hAABB);
    step(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 32'h0);

    // SWR into lanes 3..2
    step(1'b1, 3'd4, 32'h1000_0002, 32'h11223344, 1'b0, 32'h0);
    chk("swr_strb", out_strb, 32'hC);
    chk("swr_hi", out_data[31:16], 32'h3344);
    step(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 32'h0);

    // Misaligned SH
    step(1'b1, 3'd1, 32'h1000_0003, 32'h5555, 1'b0, 32'h0);
    chk("sh_ade", ade, 32'h1);
    chk("sh_ade_addr", ade_addr, 32'h1000_0003);
    chk("sh_empty", empty, 32'h1);
    step(1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 32'h0);
    chk("sh_ade_drop", ade, 32'h0);

    // Fill to full, refused push, one pop
    for (int i = 0; i < 4; i++)
      step(1'b1, 3'd2, 32'h100 + 32'(i * 4), 32'hC0DE0000 + 32'(i), 1'b0, 32'h0);
    chk("full_ready", in_ready, 32'h0);
    step(1'b1, 3'd2, 32'h200, 32'hDEADBEEF, 1'b0, 32'h0);
    step(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 32'h0);
    chk("pop_ready", in_ready, 32'h1);
    chk("order", out_addr, 32'h104);
    for (int i = 0; i < 3; i++) step(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 32'h0);

    // Write-combining into the tail
    step(1'b1, 3'd2, 32'h2000, 32'h0, 1'b0, 32'h0);
    step(1'b1, 3'd0, 32'h2004, 32'h5A, 1'b0, 32'h0);
    step(1'b1, 3'd0, 32'h2006, 32'hA5, 1'b0, 32'h2007);
    chk("hit_2007", ld_hit, 32'h1);
    step(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 32'h2008);
    chk("miss_2008", ld_hit, 32'h0);
    chk("merge_strb", out_strb, 32'h5);
    chk("merge_l0", out_data[7:0], 32'h5A);
    chk("merge_l2", out_data[23:16], 32'hA5);
    step(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 32'h2007);
    chk("drain_hit", ld_hit, 32'h0);
    chk("drain_empty", empty, 32'h1);

    // Randomized traffic over a small address window
    for (int n = 0; n < 600; n++)
      step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
           32'h3000 + 32'($urandom_range(0, 15)), $urandom,
           $urandom_range(0, 2) == 0, 32'h3000 + 32'($urandom_range(0, 19)));

    // Reset mid-operation cancels entries and the pending ade pulse
    step(1'b1, 3'd2, 32'h4000, 32'h1, 1'b0, 32'h4000);
    step(1'b1, 3'd2, 32'h4002, 32'h2, 1'b0, 32'h4000);
    chk("pre_rst_ade", ade, 32'h1);
    resetn = 1'b0;
    #1;
    q.delete();
    m_ade = 1'b0;
    m_ade_addr = 32'h0;
    check_all();
    @(posedge clk); #1;
    resetn = 1'b1;
    step(1'b1, 3'd0, 32'h5003, 32'h77, 1'b0, 32'h5000);
    step(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 32'h5000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
